win3x3_gen: RTL and testbench

- Streaming 3x3 neighbourhood generator for the dark-channel path.
- Accepts a raster-order pixel stream (one channel, or pre-reduced per-pixel min) and produces the nine taps that feed the 9-input minimum block.
- Uses two line buffers plus a 3x3 shift-register array.
- Emits only windows that lie fully inside the frame (no border padding).

---
 rtl/win3x3_gen.sv | 126 ++++++++++++
 tb/tb_win3x3_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/win3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : win3x3_gen
// Brief    : Streaming 3x3 window generator (two line buffers + 3x3 shift array)
//            emitting only fully in-frame windows, row-major taps.
// Revision : 1.0 - initial release
// ============================================================================
module win3x3_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          pix_in,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    output logic [DATA_W-1:0]          win0,
    output logic [DATA_W-1:0]          win1,
    output logic [DATA_W-1:0]          win2,
    output logic [DATA_W-1:0]          win3,
    output logic [DATA_W-1:0]          win4,
    output logic [DATA_W-1:0]          win5,
    output logic [DATA_W-1:0]          win6,
    output logic [DATA_W-1:0]          win7,
    output logic [DATA_W-1:0]          win8,
    output logic                       win_valid,
    output logic [$clog2(IMG_W)-1:0]   win_cx,
    output logic [$clog2(IMG_H)-1:0]   win_cy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);

    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    logic [CW-1:0]     col_q, col_d, pos_col;
    logic [RW-1:0]     row_q, row_d, pos_row;
    logic [DATA_W-1:0] arr_q [9];
    logic [DATA_W-1:0] arr_d [9];
    logic [DATA_W-1:0] win_q [9];
    logic              win_valid_q;
    logic [CW-1:0]     win_cx_q;
    logic [RW-1:0]     win_cy_q;
    logic              emit;

    always_comb begin
        // SOF overrides the running counters for the pixel being accepted.
        pos_col = pix_sof ? '0 : col_q;
        pos_row = pix_sof ? '0 : row_q;
        lb0_rd  = lb0_mem[pos_col];
        lb1_rd  = lb1_mem[pos_col];

        if (pos_col == C_COL_LAST) begin
            col_d = '0;
            row_d = (pos_row == C_ROW_LAST) ? '0 : pos_row + RW'(1);
        end else begin
            col_d = pos_col + CW'(1);
            row_d = pos_row;
        end

        arr_d[0] = arr_q[1];
        arr_d[1] = arr_q[2];
        arr_d[2] = lb1_rd;
        arr_d[3] = arr_q[4];
        arr_d[4] = arr_q[5];
        arr_d[5] = lb0_rd;
        arr_d[6] = arr_q[7];
        arr_d[7] = arr_q[8];
        arr_d[8] = pix_in;

        emit = pix_valid && (pos_col >= CW'(2)) && (pos_row >= RW'(2));
    end

    // Line buffers carry no reset; rows 0/1 of each frame refill them before use.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1_mem[pos_col] <= lb0_rd;
            lb0_mem[pos_col] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            arr_q       <= '{default: '0};
            win_q       <= '{default: '0};
            win_valid_q <= 1'b0;
            win_cx_q    <= '0;
            win_cy_q    <= '0;
        end else begin
            win_valid_q <= emit;
            if (pix_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                arr_q <= arr_d;
            end
            if (emit) begin
                win_q    <= arr_d;
                win_cx_q <= pos_col - CW'(1);
                win_cy_q <= pos_row - RW'(1);
            end
        end
    end

    assign win0      = win_q[0];
    assign win1      = win_q[1];
    assign win2      = win_q[2];
    assign win3      = win_q[3];
    assign win4      = win_q[4];
    assign win5      = win_q[5];
    assign win6      = win_q[6];
    assign win7      = win_q[7];
    assign win8      = win_q[8];
    assign win_valid = win_valid_q;
    assign win_cx    = win_cx_q;
    assign win_cy    = win_cy_q;

endmodule
`default_nettype wire

// File: tb/tb_win3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_win3x3_gen
// Brief    : Self-checking bench for win3x3_gen on a 5x4 frame, frame-image model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_win3x3_gen;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] pix_in = '0;
    logic              pix_valid = 1'b0;
    logic              pix_sof = 1'b0;
    logic [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic              win_valid;
    logic [CW-1:0]     win_cx;
    logic [RW-1:0]     win_cy;

    win3x3_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
        .win_valid(win_valid), .win_cx(win_cx), .win_cy(win_cy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: frame image indexed by position, plus expected registered outputs.
    logic [7:0]  img [IMG_H][IMG_W];
    int          mx, my;
    logic        exp_valid;
    logic [71:0] exp_win;
    logic [CW-1:0] exp_cx;
    logic [RW-1:0] exp_cy;

    logic [71:0] dwin [$];
    int          dcx [$];
    int          dcy [$];

    task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic model_reset();
        mx = 0; my = 0;
        exp_valid = 1'b0; exp_win = '0; exp_cx = '0; exp_cy = '0;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) img[y][x] = '0;
    endtask

    task automatic model_accept(input logic [7:0] p, input bit sof);
        int x, y;
        x = sof ? 0 : mx;
        y = sof ? 0 : my;
        img[y][x] = p;
        exp_valid = 1'b0;
        if (x >= 2 && y >= 2) begin
            exp_valid = 1'b1;
            exp_win = {img[y-2][x-2], img[y-2][x-1], img[y-2][x],
                       img[y-1][x-2], img[y-1][x-1], img[y-1][x],
                       img[y][x-2],   img[y][x-1],   img[y][x]};
            exp_cx = CW'(x - 1);
            exp_cy = RW'(y - 1);
        end
        mx = x + 1; my = y;
        if (mx == IMG_W) begin
            mx = 0;
            my = (y + 1) % IMG_H;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [71:0] got_win;
        got_win = {win0, win1, win2, win3, win4, win5, win6, win7, win8};
        chk({tag, ".valid"}, 80'(win_valid), 80'(exp_valid));
        chk({tag, ".win"},   80'(got_win),   80'(exp_win));
        chk({tag, ".cx"},    80'(win_cx),    80'(exp_cx));
        chk({tag, ".cy"},    80'(win_cy),    80'(exp_cy));
        if (win_valid) begin
            dwin.push_back(got_win);
            dcx.push_back(int'(win_cx));
            dcy.push_back(int'(win_cy));
        end
    endtask

    task automatic step(input bit v, input logic [7:0] p, input bit sof);
        @(negedge clk);
        pix_valid = v; pix_in = p; pix_sof = sof;
        if (v) model_accept(p, sof);
        else exp_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    // Sends raster indices first..last of a frame; value = base + 16*y + x.
    task automatic send_range(input logic [7:0] base, input int first, input int last,
                              input bit sof_first, input bit gap22);
        for (int n = first; n <= last; n++) begin
            logic [7:0] v;
            v = base + 8'((n / IMG_W) * 16 + (n % IMG_W));
            if (gap22 && n == 12)
                for (int g = 0; g < 3; g++) step(1'b0, 8'hEE, 1'b1);
            step(1'b1, v, sof_first && (n == first));
        end
        @(negedge clk);
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic clear_log();
        dwin.delete(); dcx.delete(); dcy.delete();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame with SOF.
        clear_log();
        send_range(8'h00, 0, 19, 1'b1, 1'b0);
        chk("t1.count", 80'(dwin.size()), 80'(6));
        if (dwin.size() == 6) begin
            chk("t1.first",    80'(dwin[0]), 80'(72'h000102101112202122));
            chk("t1.first.cx", 80'(dcx[0]),  80'(1));
            chk("t1.first.cy", 80'(dcy[0]),  80'(1));
            chk("t1.wrap",     80'(dwin[3]), 80'(72'h101112202122303132));
            chk("t1.wrap.cy",  80'(dcy[3]),  80'(2));
            chk("t1.last",     80'(dwin[5]), 80'(72'h121314222324323334));
            chk("t1.last.cx",  80'(dcx[5]),  80'(3));
            chk("t1.last.cy",  80'(dcy[5]),  80'(2));
        end

        // Gap of three idle cycles between 0x21 and 0x22.
        clear_log();
        send_range(8'h00, 0, 19, 1'b1, 1'b1);
        chk("t2.count", 80'(dwin.size()), 80'(6));
        if (dwin.size() == 6)
            chk("t2.first", 80'(dwin[0]), 80'(72'h000102101112202122));

        // Back-to-back frames, second offset by 0x80.
        clear_log();
        send_range(8'h00, 0, 19, 1'b1, 1'b0);
        send_range(8'h80, 0, 19, 1'b1, 1'b0);
        chk("t3.count", 80'(dwin.size()), 80'(12));
        if (dwin.size() == 12)
            chk("t3.f2first", 80'(dwin[6]), 80'(72'h808182909192A0A1A2));

        // SOF on the 8th pixel of a frame.
        clear_log();
        send_range(8'h00, 0, 6, 1'b1, 1'b0);
        chk("t4.pre", 80'(dwin.size()), 80'(0));
        send_range(8'h00, 0, 11, 1'b1, 1'b0);
        chk("t4.before12", 80'(dwin.size()), 80'(0));
        send_range(8'h00, 12, 12, 1'b0, 1'b0);
        chk("t4.at12", 80'(dwin.size()), 80'(1));
        send_range(8'h00, 13, 19, 1'b0, 1'b0);
        chk("t4.count", 80'(dwin.size()), 80'(6));
        if (dwin.size() == 6)
            chk("t4.first", 80'(dwin[0]), 80'(72'h000102101112202122));

        // Reset mid-frame after 0x23, then restart without SOF.
        clear_log();
        send_range(8'h00, 0, 13, 1'b1, 1'b0);
        chk("t5.pre", 80'(dwin.size()), 80'(2));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t5.rst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        send_range(8'h40, 0, 19, 1'b0, 1'b0);
        chk("t5.count", 80'(dwin.size()), 80'(6));
        if (dwin.size() == 6)
            chk("t5.first", 80'(dwin[0]), 80'(72'h404142505152606162));

        repeat (2) step(1'b0, 8'h00, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
